demodulate: RTL and testbench
=============================

# demodulate

4-FSK demodulator: receiver for the 1-bit `modulate` output stream. It recovers one 2-bit symbol per 128-clock symbol window by counting rising edges of the incoming square wave. Each recovered symbol is presented with a one-cycle valid strobe. It sits at the far end of the link, shares `clk` and `reset` with the modulator, and its symbol windows are aligned to reset release.

## Interface

Parameters:
- `SYM_LEN`, 128: clocks per symbol window; power of two.
- `TH1`, 6: minimum edge count for symbol 1.
- `TH2`, 12: minimum edge count for symbol 2.
- `TH3`, 24: minimum edge count for symbol 3.
- `CARRIER_MIN`, 2: minimum edge count for `carrier_ok` = 1.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `in`, input, 1: serial FSK line from the modulator; may be asynchronous.
- `out`, output, 2: last decided symbol.
- `valid`, output, 1: one-cycle pulse when `out` is updated.
- `carrier_ok`, output, 1: last window had at least `CARRIER_MIN` rising edges.

## Operation

Line code, fixed with the modulator, per 128-clock symbol:
- Symbol 0: half-period 16, 4 rising edges per window.
- Symbol 1: half-period 8, 8 edges.
- Symbol 2: half-period 4, 16 edges.
- Symbol 3: half-period 2, 32 edges.

Datapath:
- Input synchronizer: `in` → `s1` → `s2`, then history flop `s3`. `rise = s2 & ~s3`.
- Window counter `wcnt`: log2(`SYM_LEN`) bits (7 bits). Free-running 0..`SYM_LEN`-1, wraps to 0.
- Edge counter `ecnt`: 6 bits, increments on `rise`, saturates at 63 and never wraps.

End-of-window decision, when `wcnt` == `SYM_LEN`-1:
- Let n = `ecnt` + `rise` (the edge in the final cycle counts), saturated to 63.
- n < `TH1` → 0; `TH1` ≤ n < `TH2` → 1; `TH2` ≤ n < `TH3` → 2; n ≥ `TH3` → 3.
- Register the decision into `out`.
- `carrier_ok` ← (n ≥ `CARRIER_MIN`).
- `valid` ← 1.
- `ecnt` ← 0. An edge in that cycle is not carried into the next window.
- In all other cycles `valid` ← 0, and `out` and `carrier_ok` hold.

No other states. The window counter is the only FSM: COUNT (0..126) and DECIDE (127), with an unconditional DECIDE → COUNT transition.

## Timing

- Reset values: `out` = 0, `valid` = 0, `carrier_ok` = 0, `wcnt` = 0, `ecnt` = 0, `s1`/`s2`/`s3` = 0.
- Reset asserted mid-window:
  - Outputs clear immediately, without waiting for a clock.
  - The partial window is discarded.
  - A new window starts at the first clock edge after deassertion.
- First `valid`: 128th rising clock edge after reset deassertion (cycle index 127 is DECIDE; `valid` is high during the following cycle). Thereafter every 128 clocks exactly.
- Latency from a line edge to its count: 3 clocks (two sync flops plus the edge register).
- The first one or two edges of a new symbol can land in the prior window. This perturbs the count by at most 1. The threshold midpoints tolerate this.
- `valid` is never asserted on two consecutive cycles.
- `out` is stable between pulses.
- A constant `in` (0 or 1) yields 0 edges: `out` = 0, `carrier_ok` = 0, `valid` still pulses.
- `in` toggling every clock gives at most 64 edges per window. `ecnt` saturates at 63 → `out` = 3.

## Test plan

- Reset, then `in` = symbol 2 waveform (half-period 4) for 3 windows → three `valid` pulses 128 clocks apart, first at clock 128. `out` = 2 and `carrier_ok` = 1 on each.
- Modulator-style sequence 0,1,2,3,0,2,0,3,1,3,2,1,0, one symbol per 128 clocks, aligned to reset release → identical `out` sequence, `carrier_ok` = 1 throughout.
- Threshold boundaries: inject exactly 5, 6, 11, 12, 23, 24 rising edges, including one in the final cycle of the window → `out` = 0, 1, 1, 2, 2, 3.
- `in` held at 0 for 2 windows, then toggled every clock for 1 window:
  - Held windows → `out` = 0, `carrier_ok` = 0, `valid` pulses present.
  - Toggled window → `out` = 3, no counter wrap.
- Assert `reset` for 3 clocks at window cycle 60 while symbol 3 is streaming:
  - `out`/`valid`/`carrier_ok` go to 0 asynchronously.
  - Next `valid` comes 128 clocks after deassertion, with `out` = 3.

Source files
------------

// File: rtl/demodulate.sv
// 4-FSK demodulator: counts rising edges of the synchronised line over fixed
// SYM_LEN-clock windows aligned to reset release, then maps the count onto a
// 2-bit symbol with a one-cycle valid strobe.
module demodulate #(
  parameter int unsigned SYM_LEN     = 128,
  parameter int unsigned TH1         = 6,
  parameter int unsigned TH2         = 12,
  parameter int unsigned TH3         = 24,
  parameter int unsigned CARRIER_MIN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic [1:0] out,
  output logic       valid,
  output logic       carrier_ok
);

  localparam int unsigned WW = $clog2(SYM_LEN);
  localparam logic [WW-1:0] WLAST = WW'(SYM_LEN - 1);
  localparam logic [5:0] EMAX = 6'h3f;

  // The window counter is the only state machine; its phase is decoded from wcnt.
  typedef enum logic {StCount, StDecide} state_e;

  logic          s1, s2, s3;
  logic          rise;
  logic [WW-1:0] wcnt;
  logic [5:0]    ecnt;
  state_e        state;
  logic [6:0]    nsum;
  logic [5:0]    n;
  logic [1:0]    sym;
  logic          carrier;

  // Phase decode, final edge count (including this cycle's edge) and symbol decision.
  always_comb begin
    rise    = s2 & ~s3;
    state   = (wcnt == WLAST) ? StDecide : StCount;
    nsum    = {1'b0, ecnt} + {6'd0, rise};
    n       = nsum[6] ? EMAX : nsum[5:0];
    if (n >= 6'(TH3)) begin
      sym = 2'd3;
    end else if (n >= 6'(TH2)) begin
      sym = 2'd2;
    end else if (n >= 6'(TH1)) begin
      sym = 2'd1;
    end else begin
      sym = 2'd0;
    end
    carrier = (n >= 6'(CARRIER_MIN));
  end

  // Two-flop synchroniser for the asynchronous line plus a history flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Free-running symbol window counter; DECIDE always returns to COUNT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt <= '0;
    end else if (state == StDecide) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt + 1'b1;
    end
  end

  // Saturating edge counter; cleared at window end, dropping any edge seen in that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ecnt <= 6'd0;
    end else if (state == StDecide) begin
      ecnt <= 6'd0;
    end else if (rise && (ecnt != EMAX)) begin
      ecnt <= ecnt + 6'd1;
    end
  end

  // Registered decision outputs; out and carrier_ok hold between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out        <= 2'd0;
      valid      <= 1'b0;
      carrier_ok <= 1'b0;
    end else begin
      valid <= (state == StDecide);
      if (state == StDecide) begin
        out        <= sym;
        carrier_ok <= carrier;
      end
    end
  end

endmodule

// File: tb/tb_demodulate.sv
// Self-checking bench for demodulate: a window-level edge-counting model of the
// sampled line is compared against the DUT every cycle, plus literal expectations.
module tb_demodulate;

  logic       clk;
  logic       reset;
  logic       in;
  logic [1:0] out;
  logic       valid;
  logic       carrier_ok;

  demodulate #(
    .SYM_LEN    (128),
    .TH1        (6),
    .TH2        (12),
    .TH3        (24),
    .CARRIER_MIN(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .out       (out),
    .valid     (valid),
    .carrier_ok(carrier_ok)
  );

  int tests = 0;
  int fails = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // hist[j-1] is the line value sampled at clock edge j after reset release.
  // An edge is counted in cycle k when the line went 0->1 between samples k-2 and k-1.
  bit         hist[$];
  int         m;
  int         acc;
  int         k_m;
  int         n_m;
  logic [1:0] e_out;
  logic       e_valid;
  logic       e_cok;

  function automatic bit hx(int j);
    if (j >= 1 && j <= hist.size()) return hist[j-1];
    return 1'b0;
  endfunction

  function automatic logic [1:0] decide(int n);
    if (n >= 24) return 2'd3;
    if (n >= 12) return 2'd2;
    if (n >= 6) return 2'd1;
    return 2'd0;
  endfunction

  initial begin
    m = 0; acc = 0; e_out = 2'd0; e_valid = 1'b0; e_cok = 1'b0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        hist.delete();
        m = 0; acc = 0; e_out = 2'd0; e_valid = 1'b0; e_cok = 1'b0;
      end else begin
        k_m = m;  // cycle that just ended
        if (hx(k_m - 1) && !hx(k_m - 2)) acc++;
        hist.push_back(in);
        m++;
        if (k_m % 128 == 127) begin
          n_m     = (acc > 63) ? 63 : acc;
          e_out   = decide(n_m);
          e_cok   = (n_m >= 2);
          e_valid = 1'b1;
          acc     = 0;
        end else begin
          e_valid = 1'b0;
        end
      end
    end
  end

  // Literal per-window expectations, consumed in order by valid strobes.
  typedef struct {
    logic [1:0] sym;
    logic       cok;
  } lit_t;
  lit_t lit_q[$];
  lit_t lit;
  logic prev_valid;

  // ---------------- compare process ----------------
  initial begin
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      tests++;
      if (out !== e_out || valid !== e_valid || carrier_ok !== e_cok) begin
        fails++;
        $display("FAIL cycle_check m=%0d: got out=%0d valid=%0b carrier_ok=%0b, want out=%0d valid=%0b carrier_ok=%0b",
                 m, out, valid, carrier_ok, e_out, e_valid, e_cok);
      end
      if (valid === 1'b1) begin
        tests++;
        if (prev_valid === 1'b1) begin
          fails++;
          $display("FAIL valid_back_to_back m=%0d: got valid high twice, want single pulse", m);
        end
        tests++;
        if (m == 0 || m % 128 != 0) begin
          fails++;
          $display("FAIL valid_phase: got pulse after edge %0d, want a multiple of 128", m);
        end
        if (lit_q.size() > 0) begin
          lit = lit_q.pop_front();
          tests++;
          if (out !== lit.sym || carrier_ok !== lit.cok) begin
            fails++;
            $display("FAIL literal m=%0d: got out=%0d carrier_ok=%0b, want out=%0d carrier_ok=%0b",
                     m, out, carrier_ok, lit.sym, lit.cok);
          end
        end
      end
      prev_valid = valid;
    end
  end

  // ---------------- stimulus ----------------
  // mode 0: square wave half-period arg; 1: constant arg; 2: toggle every clock;
  // 3: exactly arg counted edges, the last one in the final window cycle; 4: noise.
  function automatic logic wave(int mode, int arg, int t);
    case (mode)
      0: return ((t / arg) % 2) != 0;
      1: return arg != 0;
      2: return (t % 2) != 0;
      3: begin
        if (t == 125) return 1'b1;
        return (t % 4 == 1) && (t / 4 < arg - 1);
      end
      default: return $urandom_range(0, 3) == 0;
    endcase
  endfunction

  // Called on the negedge that starts a window; returns on the negedge starting the next.
  task automatic run_window(int mode, int arg, bit push, logic [1:0] sym, logic cok);
    lit_t l;
    if (push) begin
      l.sym = sym;
      l.cok = cok;
      lit_q.push_back(l);
    end
    for (int t = 0; t < 128; t++) begin
      in = wave(mode, arg, t);
      @(negedge clk);
    end
  endtask

  // Confirms every expected strobe arrived.
  task automatic drain();
    @(negedge clk);
    tests++;
    if (lit_q.size() != 0) begin
      fails++;
      $display("FAIL missing_valid: got %0d unconsumed windows, want 0", lit_q.size());
    end
    lit_q.delete();
  endtask

  task automatic apply_reset();
    drain();
    reset = 1'b1;
    in    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  int seq[13] = '{0, 1, 2, 3, 0, 2, 0, 3, 1, 3, 2, 1, 0};
  int thr[6] = '{5, 6, 11, 12, 23, 24};
  logic [1:0] thr_sym[6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
  int r;
  int a;

  initial begin
    reset = 1'b1;
    in    = 1'b0;

    // Symbol 2 for three windows.
    apply_reset();
    for (int w = 0; w < 3; w++) run_window(0, 4, 1'b1, 2'd2, 1'b1);

    // Modulator-style symbol sequence.
    apply_reset();
    for (int w = 0; w < 13; w++) run_window(0, 16 >> seq[w], 1'b1, 2'(seq[w]), 1'b1);

    // Threshold boundaries.
    apply_reset();
    for (int w = 0; w < 6; w++) run_window(3, thr[w], 1'b1, thr_sym[w], 1'b1);

    // Idle line, then toggling every clock (second window saturates at 64 raw edges).
    apply_reset();
    run_window(1, 0, 1'b1, 2'd0, 1'b0);
    run_window(1, 0, 1'b1, 2'd0, 1'b0);
    run_window(2, 0, 1'b1, 2'd3, 1'b1);
    run_window(2, 0, 1'b1, 2'd3, 1'b1);

    // Reset at window cycle 60 while symbol 3 streams.
    apply_reset();
    run_window(0, 2, 1'b1, 2'd3, 1'b1);
    for (int t = 0; t < 60; t++) begin
      in = wave(0, 2, t);
      @(negedge clk);
    end
    tests++;
    if (out !== 2'd3 || carrier_ok !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: got out=%0d carrier_ok=%0b, want out=3 carrier_ok=1", out, carrier_ok);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (out !== 2'd0 || valid !== 1'b0 || carrier_ok !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got out=%0d valid=%0b carrier_ok=%0b, want all 0",
               out, valid, carrier_ok);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_window(0, 2, 1'b1, 2'd3, 1'b1);

    // Randomised windows, checked by the model only.
    apply_reset();
    for (int w = 0; w < 24; w++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: a = 16 >> $urandom_range(0, 3);
        1: a = $urandom_range(0, 1);
        3: a = $urandom_range(1, 31);
        default: a = 0;
      endcase
      run_window(r, a, 1'b0, 2'd0, 1'b0);
    end

    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
